// File: rtl/eq_ui_pkg.sv
// Shared constants and types for the equalizer slider controller.
//   NUM_CH/LVL_W/SEL_W : channel count and field widths
//   LEVEL_MAX/LEVEL_RST: gain range top and reset level
//   KEY_*              : bit positions of the keys in key_n
//   pick_event()       : fixed-priority selection of one key event per cycle
package eq_ui_pkg;

    localparam int unsigned NUM_CH    = 6;
    localparam int unsigned LVL_W     = 4;
    localparam int unsigned SEL_W     = 3;
    localparam int unsigned NUM_KEYS  = 4;
    localparam int unsigned LEVEL_MAX = 14;
    localparam int unsigned LEVEL_RST = 7;

    localparam int unsigned KEY_RIGHT = 0;
    localparam int unsigned KEY_LEFT  = 1;
    localparam int unsigned KEY_DOWN  = 2;
    localparam int unsigned KEY_UP    = 3;

    typedef enum logic [2:0] {
        EV_NONE,
        EV_UP,
        EV_DOWN,
        EV_LEFT,
        EV_RIGHT
    } ev_e;

    // Up beats down beats left beats right; the losers are simply dropped.
    function automatic ev_e pick_event(input logic [NUM_KEYS-1:0] ev);
        if (ev[KEY_UP])         return EV_UP;
        else if (ev[KEY_DOWN])  return EV_DOWN;
        else if (ev[KEY_LEFT])  return EV_LEFT;
        else if (ev[KEY_RIGHT]) return EV_RIGHT;
        else                    return EV_NONE;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Single-key conditioner: 2-flop synchronizer, debounce counter, press pulse.
//   pclk, rst_n : clock, async active-low reset
//   key_n       : raw key, active-low
//   o_pressed   : debounced key state (1 = pressed)
//   o_press     : one-cycle pulse on a debounced released->pressed transition
module key_debounce #(
    parameter int unsigned DEB_CNT = 1485000
) (
    input  logic pclk,
    input  logic rst_n,
    input  logic key_n,
    output logic o_pressed,
    output logic o_press
);

    localparam int unsigned CNT_W = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             stable_q, stable_d;
    logic             prev_q, prev_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Internal polarity is "1 = pressed" from the first sync flop onward.
    always_comb begin
        sync1_d  = ~key_n;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        cnt_d    = cnt_q;
        prev_d   = stable_q;
        press_d  = stable_q & ~prev_q;
        if (sync2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_W'(DEB_CNT - 1)) begin
            stable_d = sync2_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            prev_q   <= 1'b0;
            press_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            prev_q   <= prev_d;
            press_q  <= press_d;
            cnt_q    <= cnt_d;
        end
    end

    assign o_pressed = stable_q;
    assign o_press   = press_q;

endmodule

// File: rtl/eq_slider_ctrl.sv
// Equalizer slider controller: key handling, channel cursor, per-channel gain,
// frame-synchronous publication of select/levels at vertical sync.
//   pclk, rst_n : pixel clock, async active-low reset
//   key_n[3:0]  : raw keys, active-low ([3] up, [2] down, [1] left, [0] right)
//   i_vs        : vertical sync, active-high; commit on its rising edge
//   o_sel       : committed channel (0..5)
//   o_level     : committed levels, channel n in [4n+3:4n]
//   o_upd       : one-cycle pulse when a commit changed o_sel or o_level
// Build option: EQ_AUTOREPEAT_EN adds hold-to-repeat on the up/down keys.
module eq_slider_ctrl
    import eq_ui_pkg::*;
#(
    parameter int unsigned DEB_CNT       = 1485000
`ifdef EQ_AUTOREPEAT_EN
    , parameter int unsigned REPEAT_START  = 37125000
    , parameter int unsigned REPEAT_PERIOD = 7425000
`endif
) (
    input  logic                    pclk,
    input  logic                    rst_n,
    input  logic [NUM_KEYS-1:0]     key_n,
    input  logic                    i_vs,
    output logic [SEL_W-1:0]        o_sel,
    output logic [NUM_CH*LVL_W-1:0] o_level,
    output logic                    o_upd
);

    localparam int unsigned LEV_BITS = NUM_CH * LVL_W;
    localparam logic [LVL_W-1:0]    LVL_RST_V = LVL_W'(LEVEL_RST);
    localparam logic [LEV_BITS-1:0] LEV_RST_V = {NUM_CH{LVL_RST_V}};

    logic [NUM_KEYS-1:0] key_held;
    logic [NUM_KEYS-1:0] key_press;
    logic [NUM_KEYS-1:0] key_rep;
    logic [NUM_KEYS-1:0] key_ev;

    // One conditioner per key.
    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        key_debounce #(.DEB_CNT(DEB_CNT)) u_deb (
            .pclk      (pclk),
            .rst_n     (rst_n),
            .key_n     (key_n[k]),
            .o_pressed (key_held[k]),
            .o_press   (key_press[k])
        );
    end

`ifdef EQ_AUTOREPEAT_EN
    localparam int unsigned REP_MAX = (REPEAT_START > REPEAT_PERIOD) ? REPEAT_START : REPEAT_PERIOD;
    localparam int unsigned REP_W   = $clog2(REP_MAX + 1);

    // Slot 0 tracks up, slot 1 tracks down.
    logic [REP_W-1:0] rep_cnt_q [2];
    logic [REP_W-1:0] rep_cnt_d [2];
    logic [1:0]       rep_ph_q, rep_ph_d;
    logic [1:0]       rep_fire_q, rep_fire_d;
    logic [1:0]       rep_held;

    assign rep_held = {key_held[KEY_DOWN], key_held[KEY_UP]};

    // Counter holds cycles since the last event; phase bit selects start vs period.
    always_comb begin
        for (int r = 0; r < 2; r++) begin
            rep_cnt_d[r]  = rep_cnt_q[r];
            rep_ph_d[r]   = rep_ph_q[r];
            rep_fire_d[r] = 1'b0;
            if (!rep_held[r]) begin
                rep_cnt_d[r] = '0;
                rep_ph_d[r]  = 1'b0;
            end else if (!rep_ph_q[r] && rep_cnt_q[r] == REP_W'(REPEAT_START)) begin
                rep_fire_d[r] = 1'b1;
                rep_ph_d[r]   = 1'b1;
                rep_cnt_d[r]  = REP_W'(1);
            end else if (rep_ph_q[r] && rep_cnt_q[r] == REP_W'(REPEAT_PERIOD)) begin
                rep_fire_d[r] = 1'b1;
                rep_cnt_d[r]  = REP_W'(1);
            end else begin
                rep_cnt_d[r] = rep_cnt_q[r] + REP_W'(1);
            end
        end
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            rep_cnt_q[0] <= '0;
            rep_cnt_q[1] <= '0;
            rep_ph_q     <= '0;
            rep_fire_q   <= '0;
        end else begin
            rep_cnt_q[0] <= rep_cnt_d[0];
            rep_cnt_q[1] <= rep_cnt_d[1];
            rep_ph_q     <= rep_ph_d;
            rep_fire_q   <= rep_fire_d;
        end
    end

    always_comb begin
        key_rep           = '0;
        key_rep[KEY_UP]   = rep_fire_q[0];
        key_rep[KEY_DOWN] = rep_fire_q[1];
    end
`else
    assign key_rep = '0;
`endif

    assign key_ev = key_press | key_rep;

    logic [SEL_W-1:0]    sel_w_q, sel_w_d;
    logic [LEV_BITS-1:0] lvl_w_q, lvl_w_d;
    logic [SEL_W-1:0]    out_sel_q, out_sel_d;
    logic [LEV_BITS-1:0] out_lvl_q, out_lvl_d;
    logic                upd_q, upd_d;
    logic                vs_q, vs_d;
    logic                commit;
    ev_e                 ev_sel;
    logic [LVL_W-1:0]    cur_lvl;
    logic [LVL_W-1:0]    new_lvl;

    // Working-state update from the winning event.
    always_comb begin
        sel_w_d = sel_w_q;
        lvl_w_d = lvl_w_q;
        ev_sel  = pick_event(key_ev);
        cur_lvl = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (sel_w_q == SEL_W'(ch)) cur_lvl = lvl_w_q[ch*LVL_W +: LVL_W];
        end
        new_lvl = cur_lvl;
        case (ev_sel)
            EV_UP:    if (cur_lvl < LVL_W'(LEVEL_MAX)) new_lvl = cur_lvl + LVL_W'(1);
            EV_DOWN:  if (cur_lvl != '0) new_lvl = cur_lvl - LVL_W'(1);
            EV_LEFT:  sel_w_d = (sel_w_q == '0) ? SEL_W'(NUM_CH - 1) : sel_w_q - SEL_W'(1);
            EV_RIGHT: sel_w_d = (sel_w_q == SEL_W'(NUM_CH - 1)) ? '0 : sel_w_q + SEL_W'(1);
            default:  ;
        endcase
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (sel_w_q == SEL_W'(ch)) lvl_w_d[ch*LVL_W +: LVL_W] = new_lvl;
        end
    end

    // Commit on i_vs rise using the pre-event working values.
    always_comb begin
        vs_d      = i_vs;
        commit    = i_vs & ~vs_q;
        out_sel_d = out_sel_q;
        out_lvl_d = out_lvl_q;
        upd_d     = 1'b0;
        if (commit) begin
            out_sel_d = sel_w_q;
            out_lvl_d = lvl_w_q;
            upd_d     = (sel_w_q != out_sel_q) || (lvl_w_q != out_lvl_q);
        end
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            sel_w_q   <= '0;
            lvl_w_q   <= LEV_RST_V;
            out_sel_q <= '0;
            out_lvl_q <= LEV_RST_V;
            upd_q     <= 1'b0;
            vs_q      <= 1'b0;
        end else begin
            sel_w_q   <= sel_w_d;
            lvl_w_q   <= lvl_w_d;
            out_sel_q <= out_sel_d;
            out_lvl_q <= out_lvl_d;
            upd_q     <= upd_d;
            vs_q      <= vs_d;
        end
    end

    assign o_sel   = out_sel_q;
    assign o_level = out_lvl_q;
    assign o_upd   = upd_q;

endmodule
